// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common-data-bus arbiter that moves functional-unit results through
//   one-entry holding buffers onto a single registered broadcast bus.
// Latency: a result accepted on edge k is broadcast in the cycle after edge k+1
//   when it does not have to wait for other requesters.
// Backpressure: req_ready[i] is low only while buffer i is full and not granted.
//   A granted buffer can be refilled on the same edge, so one result per cycle is sustained.
//
// Ports:
//   CLOCK_50, RSTN_N         clock, async active-low reset
//   flush                    synchronous discard of every pending result
//   req_valid/req_data       per-tag result offer (slice i-1 = tag i)
//   req_ready                per-tag accept
//   cdb_valid/cdb_tag/data   registered broadcast (all zero when idle)
//   pending                  per-tag buffer-full flags
// Option: define CDB_ROUND_ROBIN_EN for round-robin grant (default: lowest tag wins).
module cdb_arbiter #(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 2,
  parameter int NUM_REQ = 3
) (
  input  logic                      CLOCK_50,
  input  logic                      RSTN_N,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [NUM_REQ-1:0]        pending
);

  logic [NUM_REQ-1:0]             full_q, full_d;
  logic [NUM_REQ-1:0][DATA_W-1:0] buf_q, buf_d;
  logic                           cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]               cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]              cdb_data_q, cdb_data_d;

  logic [NUM_REQ-1:0]             grant;
  logic                           gnt_any;
  logic [TAG_W-1:0]               gnt_tag;
  logic [DATA_W-1:0]              gnt_data;

`ifdef CDB_ROUND_ROBIN_EN
  // Pointer holds the last granted tag (1..NUM_REQ); reset value NUM_REQ makes
  // the first search start at tag 1.
  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
  int               start_idx;

  always_comb begin
    grant     = '0;
    gnt_any   = 1'b0;
    gnt_tag   = '0;
    gnt_data  = '0;
    // Zero-based index of the tag after the last grant, wrapping NUM_REQ -> 1.
    start_idx = (int'(rr_ptr_q) >= NUM_REQ) ? 0 : int'(rr_ptr_q);
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!gnt_any && (i == (start_idx + off) % NUM_REQ) && full_q[i]) begin
          grant[i] = 1'b1;
          gnt_any  = 1'b1;
          gnt_tag  = TAG_W'(i + 1);
          gnt_data = buf_q[i];
        end
      end
    end
  end

  // Flush freezes the pointer along with discarding the grant.
  assign rr_ptr_d = (gnt_any && !flush) ? gnt_tag : rr_ptr_q;

  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) rr_ptr_q <= TAG_W'(NUM_REQ);
    else         rr_ptr_q <= rr_ptr_d;
  end
`else
  // Fixed priority: scanning from the top down leaves the lowest full tag.
  always_comb begin
    grant    = '0;
    gnt_any  = 1'b0;
    gnt_tag  = '0;
    gnt_data = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (full_q[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        gnt_any  = 1'b1;
        gnt_tag  = TAG_W'(i + 1);
        gnt_data = buf_q[i];
      end
    end
  end
`endif

  // A granted buffer drains on this edge, so it may accept a replacement now.
  assign req_ready = ~full_q | grant;

  always_comb begin
    full_d      = full_q;
    buf_d       = buf_q;
    cdb_valid_d = gnt_any;
    cdb_tag_d   = gnt_tag;
    cdb_data_d  = gnt_data;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) full_d[i] = 1'b0;
      if (req_valid[i] && req_ready[i] && !flush) begin
        full_d[i] = 1'b1;
        buf_d[i]  = req_data[i*DATA_W +: DATA_W];
      end
    end
    if (flush) begin
      full_d      = '0;
      cdb_valid_d = 1'b0;
      cdb_tag_d   = '0;
      cdb_data_d  = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      full_q      <= '0;
      buf_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
    end else begin
      full_q      <= full_d;
      buf_q       <= buf_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign pending   = full_q;

endmodule
